// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with PC, two-entry {inst, pc} buffer and redirect flush
// Optional feature macro: FETCH_PERF_CNT_EN adds the fetch_count push counter output.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] fetch_addr,
    output logic        fetch_req,
    input  logic [31:0] request_data,
    input  logic        fetch_data_valid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [31:0] pc;
    logic [1:0]  count, count_d;
    logic        rd_ptr, wr_ptr;
    logic [31:0] buf_data [2];
    logic [31:0] buf_pc   [2];
    logic        push, pop;

    assign fetch_addr = {2'b00, pc[31:2]};
    assign inst_valid = (count != 2'd0);
    assign inst_out   = inst_valid ? buf_data[rd_ptr] : 32'h0;
    assign inst_pc    = inst_valid ? buf_pc[rd_ptr]   : 32'h0;

    // fetch_req already excludes redirect cycles, so a redirect discards the push
    always_comb begin
        push    = fetch_req & fetch_data_valid;
        pop     = inst_valid & inst_ready;
        count_d = count;
        if (redirect_valid) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count + 2'd1;
                2'b01:   count_d = count - 2'd1;
                default: count_d = count;
            endcase
        end
    end

    always_comb begin
        state_d   = state;
        fetch_req = 1'b0;
        case (state)
            FETCH: begin
                fetch_req = rst && (count < 2'd2) && !redirect_valid;
                if (count_d == 2'd2) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = FETCH;
                end
            end
            FLUSH:   state_d = FETCH;
            default: state_d = FETCH;
        endcase
        if (redirect_valid) begin
            state_d = FLUSH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc           <= RESET_PC;
            count        <= 2'd0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            misalign_err <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= 32'h0;
                buf_pc[i]   <= 32'h0;
            end
        end else begin
            count <= count_d;
            if (redirect_valid) begin
                pc     <= {redirect_pc[31:2], 2'b00};
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                if (redirect_pc[1:0] != 2'b00) begin
                    misalign_err <= 1'b1;
                end
            end else begin
                if (push) begin
                    buf_data[wr_ptr] <= request_data;
                    buf_pc[wr_ptr]   <= pc;
                    wr_ptr           <= ~wr_ptr;
                    pc               <= pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count <= 32'h0;
        end else if (push) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - table-driven bench for fetch_unit (reset, streaming, stall, redirect, wrap)
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] fetch_addr;
    logic        fetch_req;
    logic [31:0] request_data;
    logic        fetch_data_valid = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_addr       (fetch_addr),
        .fetch_req        (fetch_req),
        .request_data     (request_data),
        .fetch_data_valid (fetch_data_valid),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .inst_out         (inst_out),
        .inst_pc          (inst_pc),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .misalign_err     (misalign_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count      (fetch_count)
`endif
    );

    // instruction memory: word i holds an addi-like encoding tagged with i
    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[11:0], 20'h00013};
    endfunction

    always_comb request_data = word(fetch_addr);

    typedef struct {
        logic        rst;
        logic        fdv;
        logic        rdv;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] ipc;
        logic        mis;
    } vec_t;

    vec_t vecs[32];

    function automatic vec_t mk(input logic r, input logic f, input logic rv, input logic [31:0] rp,
                                input logic rd, input logic q, input logic [31:0] a, input logic v,
                                input logic [31:0] p, input logic m);
        vec_t t;
        t.rst = r; t.fdv = f; t.rdv = rv; t.rpc = rp; t.rdy = rd;
        t.req = q; t.addr = a; t.iv = v; t.ipc = p; t.mis = m;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d actual %h required %h", name, idx, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        //             rst fdv rdv rpc            rdy | req addr          iv ipc            mis
        vecs[0]  = mk(0, 1, 0, 32'h0,          1,  0, 32'h0,          0, 32'h0,          0);
        vecs[1]  = mk(1, 1, 0, 32'h0,          1,  1, 32'h0,          0, 32'h0,          0);
        vecs[2]  = mk(1, 1, 0, 32'h0,          1,  1, 32'h1,          1, 32'h0,          0);
        vecs[3]  = mk(1, 1, 0, 32'h0,          1,  1, 32'h2,          1, 32'h4,          0);
        vecs[4]  = mk(1, 1, 0, 32'h0,          0,  1, 32'h3,          1, 32'h8,          0);
        vecs[5]  = mk(1, 1, 0, 32'h0,          0,  0, 32'h4,          1, 32'h8,          0);
        vecs[6]  = mk(1, 1, 0, 32'h0,          0,  0, 32'h4,          1, 32'h8,          0);
        vecs[7]  = mk(1, 1, 0, 32'h0,          1,  0, 32'h4,          1, 32'h8,          0);
        vecs[8]  = mk(1, 1, 0, 32'h0,          1,  1, 32'h4,          1, 32'hC,          0);
        vecs[9]  = mk(1, 0, 0, 32'h0,          1,  1, 32'h5,          1, 32'h10,         0);
        vecs[10] = mk(1, 0, 0, 32'h0,          1,  1, 32'h5,          0, 32'h0,          0);
        vecs[11] = mk(1, 0, 0, 32'h0,          1,  1, 32'h5,          0, 32'h0,          0);
        vecs[12] = mk(1, 1, 0, 32'h0,          0,  1, 32'h5,          0, 32'h0,          0);
        vecs[13] = mk(1, 1, 0, 32'h0,          0,  1, 32'h6,          1, 32'h14,         0);
        vecs[14] = mk(1, 1, 1, 32'h10,         0,  0, 32'h7,          1, 32'h14,         0);
        vecs[15] = mk(1, 1, 0, 32'h0,          1,  0, 32'h4,          0, 32'h0,          0);
        vecs[16] = mk(1, 1, 0, 32'h0,          1,  1, 32'h4,          0, 32'h0,          0);
        vecs[17] = mk(1, 1, 1, 32'h6,          1,  0, 32'h5,          1, 32'h10,         0);
        vecs[18] = mk(1, 1, 0, 32'h0,          1,  0, 32'h1,          0, 32'h0,          1);
        vecs[19] = mk(1, 1, 0, 32'h0,          1,  1, 32'h1,          0, 32'h0,          1);
        vecs[20] = mk(1, 1, 1, 32'hFFFF_FFFC,  1,  0, 32'h2,          1, 32'h4,          1);
        vecs[21] = mk(1, 1, 0, 32'h0,          0,  0, 32'h3FFF_FFFF,  0, 32'h0,          1);
        vecs[22] = mk(1, 1, 0, 32'h0,          0,  1, 32'h3FFF_FFFF,  0, 32'h0,          1);
        vecs[23] = mk(1, 1, 0, 32'h0,          0,  1, 32'h0,          1, 32'hFFFF_FFFC,  1);
        vecs[24] = mk(1, 1, 0, 32'h0,          1,  0, 32'h1,          1, 32'hFFFF_FFFC,  1);
        vecs[25] = mk(1, 1, 0, 32'h0,          1,  1, 32'h1,          1, 32'h0,          1);
        vecs[26] = mk(1, 1, 1, 32'h40,         1,  0, 32'h2,          1, 32'h4,          1);
        vecs[27] = mk(1, 1, 1, 32'h80,         1,  0, 32'h10,         0, 32'h0,          1);
        vecs[28] = mk(1, 1, 0, 32'h0,          1,  0, 32'h20,         0, 32'h0,          1);
        vecs[29] = mk(1, 1, 0, 32'h0,          1,  1, 32'h20,         0, 32'h0,          1);
        vecs[30] = mk(0, 1, 0, 32'h0,          1,  0, 32'h0,          0, 32'h0,          0);
        vecs[31] = mk(1, 1, 0, 32'h0,          1,  1, 32'h0,          0, 32'h0,          0);

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rst              = vecs[i].rst;
            fetch_data_valid = vecs[i].fdv;
            redirect_valid   = vecs[i].rdv;
            redirect_pc      = vecs[i].rpc;
            inst_ready       = vecs[i].rdy;
            #1;
            chk("fetch_req",    i, {31'h0, fetch_req},    {31'h0, vecs[i].req});
            chk("fetch_addr",   i, fetch_addr,            vecs[i].addr);
            chk("inst_valid",   i, {31'h0, inst_valid},   {31'h0, vecs[i].iv});
            chk("inst_pc",      i, inst_pc,               vecs[i].ipc);
            chk("inst_out",     i, inst_out,              vecs[i].iv ? word(vecs[i].ipc >> 2) : 32'h0);
            chk("misalign_err", i, {31'h0, misalign_err}, {31'h0, vecs[i].mis});
`ifdef FETCH_PERF_CNT_EN
            if (i == 29) chk("fetch_count", i, fetch_count, 32'd12);
            if (i == 30) chk("fetch_count_rst", i, fetch_count, 32'd0);
`endif
        end

        // misaligned redirect stays sticky while the buffer refills
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h22; inst_ready = 1'b0; fetch_data_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("seq_flush_req", 100, {31'h0, fetch_req}, 32'h0);
        chk("seq_mis0",      100, {31'h0, misalign_err}, 32'h1);
        @(negedge clk);
        #1;
        chk("seq_refetch_addr", 101, fetch_addr, 32'h8);
        chk("seq_mis1",         101, {31'h0, misalign_err}, 32'h1);
        @(negedge clk);
        #1;
        chk("seq_head_pc", 102, inst_pc, 32'h20);
        @(negedge clk);
        #1;
        chk("seq_full_req", 103, {31'h0, fetch_req}, 32'h0);
        chk("seq_full_pc",  103, inst_pc, 32'h20);
        chk("seq_mis2",     103, {31'h0, misalign_err}, 32'h1);

        // asynchronous reset between clock edges with a full buffer
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_req",   104, {31'h0, fetch_req}, 32'h0);
        chk("arst_valid", 104, {31'h0, inst_valid}, 32'h0);
        chk("arst_out",   104, inst_out, 32'h0);
        chk("arst_pc",    104, inst_pc, 32'h0);
        chk("arst_addr",  104, fetch_addr, 32'h0);
        chk("arst_mis",   104, {31'h0, misalign_err}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_req", 105, {31'h0, fetch_req}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of the first fetched instruction.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port fetch_addr  output  32  word index to instruction memory, {2'b00, pc[31:2]}.
REQ-005 SHALL have port fetch_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port request_data  input  32  instruction word returned by instruction memory.
REQ-007 SHALL have port fetch_data_valid  input  1  request_data valid this cycle.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect from execute.
REQ-009 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-010 SHALL have port inst_out  output  32  instruction at buffer head.
REQ-011 SHALL have port inst_pc  output  32  byte PC of inst_out.
REQ-012 SHALL have port inst_valid  output  1  buffer head valid to decode.
REQ-013 SHALL have port inst_ready  input  1  decode accepts head this cycle.
REQ-014 SHALL have port misalign_err  output  1  sticky flag, misaligned redirect seen.

Function
REQ-015 SHALL hold a 32-bit pc register and a 2-entry FIFO of {instruction, pc} pairs with 2-bit occupancy count (0..2).
REQ-016 SHALL implement FSM states FETCH (requesting), FULL (FIFO full, no request), FLUSH (one idle cycle after redirect).
REQ-017 SHALL drive fetch_req = 1 only in FETCH with count < 2 and redirect_valid = 0; fetch_req = 0 otherwise.
REQ-018 SHALL, on a cycle with fetch_req && fetch_data_valid, push {request_data, pc} at the clock edge and set pc <= pc + 4.
REQ-019 SHALL, on fetch_req && !fetch_data_valid, hold pc and push nothing; the same address is re-requested next cycle.
REQ-020 SHALL wrap pc from 32'hFFFF_FFFC to 32'h0000_0000 (modulo-2^32 add).
REQ-021 SHALL drive inst_valid = (count != 0), inst_out/inst_pc from head entry; both 0 when count = 0.
REQ-022 SHALL pop the head on inst_valid && inst_ready at the clock edge.
REQ-023 SHALL leave count unchanged on simultaneous push and pop; order preserved.
REQ-024 SHALL transition FETCH->FULL when count becomes 2, FULL->FETCH when a pop occurs; in FULL with pop, fetch resumes the next cycle (no same-cycle request).
REQ-025 SHALL, on redirect_valid = 1 (highest priority, any state), clear the FIFO (count <= 0), discard any same-cycle push, set pc <= {redirect_pc[31:2], 2'b00}, and enter FLUSH.
REQ-026 SHALL treat a pop coinciding with redirect as consumed; no entry survives.
REQ-027 SHALL set misalign_err <= 1 when redirect_valid && redirect_pc[1:0] != 0; cleared only by reset.
REQ-028 SHALL move FLUSH->FETCH unconditionally after one cycle unless redirect_valid re-asserts (stay FLUSH, reload pc).
REQ-029 SHALL have fetch-to-inst_valid latency of one cycle (data sampled at edge, visible next cycle).

Reset
REQ-030 SHALL, while rst = 0, asynchronously force pc = RESET_PC, count = 0, state = FETCH, misalign_err = 0, FIFO storage = 0.
REQ-031 SHALL hold fetch_req = 0, inst_valid = 0, inst_out = 0, inst_pc = 0 while rst = 0.
REQ-032 SHALL issue the first request (fetch_addr = RESET_PC>>2) in the first cycle after rst deasserts.

Configuration
REQ-033 SHALL, when macro FETCH_PERF_CNT_EN is defined, add output fetch_count (32 bits) counting successful pushes, reset to 0, wrapping, not cleared by redirect.
REQ-034 SHALL, when FETCH_PERF_CNT_EN is undefined, omit fetch_count port and logic entirely; all other behaviour identical.

Verification
REQ-035 SHALL cover reset release, RESET_PC=0, memory words 0..5 = 32'h00000013.. , inst_ready=1 -> fetch_addr 0,1,2.. per cycle; inst_pc 0,4,8 one cycle later.
REQ-036 SHALL cover inst_ready=0 for 5 cycles -> count reaches 2, fetch_req=0, pc=8; ready=1 -> entries pc 0,4 in order, fetch resumes at word 2.
REQ-037 SHALL cover redirect_pc=32'h10 with count=2 -> next cycle inst_valid=0, fetch_req=0 (FLUSH), following cycle fetch_addr=4.
REQ-038 SHALL cover redirect_pc=32'h0000_0006 -> pc=4, misalign_err=1 held until rst.
REQ-039 SHALL cover fetch_data_valid=0 for 3 cycles -> fetch_addr held, no push, no pc increment.
REQ-040 SHALL cover redirect to 32'hFFFF_FFFC -> after push, next fetch_addr=0; with FETCH_PERF_CNT_EN, fetch_count increments per push.
